// File: rtl/mpu_frame_asm.sv
// Assembles a 14-byte MPU burst read into seven signed 16-bit samples.
// Samples are published atomically one cycle after the last byte arrives.
module mpu_frame_asm #(
    parameter int NUM_BYTES   = 14,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic [15:0] temp,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0] TIMER_MAX = TMR_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PUBLISH,
        ABORT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] byteIdx_q, byteIdx_d;
    logic [TMR_W-1:0] idleTimer_q, idleTimer_d;
    logic             restartErr_q, restartErr_d;
    logic [7:0]       shadow_q [NUM_BYTES];
    logic [7:0]       shadow_d [NUM_BYTES];
    logic [15:0]      sample_q [7];
    logic [15:0]      frame_cnt_q;
    logic             publishLoad;

    always_comb begin
        state_d      = state_q;
        byteIdx_d    = byteIdx_q;
        idleTimer_d  = idleTimer_q;
        restartErr_d = 1'b0;
        shadow_d     = shadow_q;
        publishLoad  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d     = COLLECT;
                    byteIdx_d   = '0;
                    idleTimer_d = '0;
                end
            end
            COLLECT: begin
                // A new frame_start outranks a coincident byte and restarts the frame.
                if (frame_start) begin
                    restartErr_d = 1'b1;
                    byteIdx_d    = '0;
                    idleTimer_d  = '0;
                end else if (byte_valid) begin
                    shadow_d[byteIdx_q] = byte_data;
                    idleTimer_d         = '0;
                    if (byteIdx_q == LAST_IDX) begin
                        state_d     = PUBLISH;
                        byteIdx_d   = '0;
                        publishLoad = 1'b1;
                    end else begin
                        byteIdx_d = byteIdx_q + IDX_W'(1);
                    end
                end else if (idleTimer_q == TIMER_MAX) begin
                    state_d = ABORT;
                end else begin
                    idleTimer_d = idleTimer_q + TMR_W'(1);
                end
            end
            PUBLISH: state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs load from shadow_d so the final byte lands in the same edge as entry to PUBLISH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byteIdx_q    <= '0;
            idleTimer_q  <= '0;
            restartErr_q <= 1'b0;
            frame_cnt_q  <= '0;
            for (int i = 0; i < NUM_BYTES; i++) shadow_q[i] <= '0;
            for (int w = 0; w < 7; w++) sample_q[w] <= '0;
        end else begin
            state_q      <= state_d;
            byteIdx_q    <= byteIdx_d;
            idleTimer_q  <= idleTimer_d;
            restartErr_q <= restartErr_d;
            shadow_q     <= shadow_d;
            if (publishLoad) begin
                for (int w = 0; w < 7; w++) sample_q[w] <= {shadow_d[2*w], shadow_d[2*w+1]};
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign accel_x     = sample_q[0];
    assign accel_y     = sample_q[1];
    assign accel_z     = sample_q[2];
    assign temp        = sample_q[3];
    assign gyro_x      = sample_q[4];
    assign gyro_y      = sample_q[5];
    assign gyro_z      = sample_q[6];
    assign frame_cnt   = frame_cnt_q;
    assign frame_valid = (state_q == PUBLISH);
    assign frame_err   = (state_q == ABORT) || restartErr_q;
    assign busy        = (state_q == COLLECT) || (state_q == PUBLISH);

endmodule

// File: tb/tb_mpu_frame_asm.sv
// Bench for mpu_frame_asm: a byte-queue frame model checked every cycle,
// plus literal expectations for the nominal, signed, timeout, restart, wrap and reset cases.
module tb_mpu_frame_asm;

    localparam int NB = 14;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z, frame_cnt;
    logic        frame_valid, frame_err, busy;

    int vecCount = 0;
    int missCount = 0;

    logic [7:0]  mBytes[$];
    logic [15:0] mSamp [7] = '{default: 16'h0000};
    logic [15:0] mCnt = 16'h0000;
    logic        mInFrame = 1'b0;
    logic        mHold = 1'b0;
    int          mIdle = 0;
    logic        mValid = 1'b0, mErr = 1'b0, mBusy = 1'b0;
    logic        nv, ne;
    logic        forceCntReq = 1'b0;

    mpu_frame_asm #(.NUM_BYTES(NB), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .byte_valid(byte_valid),
        .byte_data(byte_data), .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .temp(temp), .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic fs, input logic bv, input logic [7:0] d);
        @(negedge clk);
        frame_start = fs;
        byte_valid  = bv;
        byte_data   = d;
    endtask

    task automatic sendFrame(input logic [7:0] first);
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < NB; i++) applyStimulus(1'b0, 1'b1, first + 8'(i));
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // Frame model: bytes queue up after a frame_start; a full queue publishes,
    // too long a silence or a restart aborts. The cycle after publish/abort ignores inputs.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mBytes.delete();
                mInFrame = 1'b0; mHold = 1'b0; mIdle = 0; mCnt = 16'h0000;
                mValid = 1'b0; mErr = 1'b0; mBusy = 1'b0;
                for (int w = 0; w < 7; w++) mSamp[w] = 16'h0000;
            end else begin
                nv = 1'b0;
                ne = 1'b0;
                if (forceCntReq) mCnt = 16'hFFFF;
                if (mHold) begin
                    mHold = 1'b0;
                end else if (!mInFrame) begin
                    if (frame_start) begin
                        mInFrame = 1'b1; mBytes.delete(); mIdle = 0;
                    end
                end else if (frame_start) begin
                    mBytes.delete(); mIdle = 0; ne = 1'b1;
                end else if (byte_valid) begin
                    mBytes.push_back(byte_data);
                    mIdle = 0;
                    if (mBytes.size() == NB) begin
                        for (int w = 0; w < 7; w++) mSamp[w] = {mBytes[2*w], mBytes[2*w+1]};
                        mCnt = mCnt + 16'd1;
                        nv = 1'b1; mInFrame = 1'b0; mHold = 1'b1;
                    end
                end else begin
                    mIdle++;
                    if (mIdle > TO) begin
                        ne = 1'b1; mInFrame = 1'b0; mHold = 1'b1;
                    end
                end
                mValid = nv;
                mErr   = ne;
                mBusy  = mInFrame || nv;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("frame_valid", {15'd0, frame_valid}, {15'd0, mValid});
            checkOutput("frame_err",   {15'd0, frame_err},   {15'd0, mErr});
            checkOutput("busy",        {15'd0, busy},        {15'd0, mBusy});
            checkOutput("frame_cnt",   frame_cnt, mCnt);
            checkOutput("accel_x", accel_x, mSamp[0]);
            checkOutput("accel_y", accel_y, mSamp[1]);
            checkOutput("accel_z", accel_z, mSamp[2]);
            checkOutput("temp",    temp,    mSamp[3]);
            checkOutput("gyro_x",  gyro_x,  mSamp[4]);
            checkOutput("gyro_y",  gyro_y,  mSamp[5]);
            checkOutput("gyro_z",  gyro_z,  mSamp[6]);
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        checkOutput("rst_accel_x", accel_x, 16'h0000);
        checkOutput("rst_cnt", frame_cnt, 16'h0000);
        checkOutput("rst_busy", {15'd0, busy}, 16'h0000);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Nominal frame 01..0E
        sendFrame(8'h01);
        checkOutput("nom_valid", {15'd0, frame_valid}, 16'h0001);
        checkOutput("nom_accel_x", accel_x, 16'h0102);
        checkOutput("nom_accel_z", accel_z, 16'h0506);
        checkOutput("nom_temp", temp, 16'h0708);
        checkOutput("nom_gyro_z", gyro_z, 16'h0D0E);
        checkOutput("nom_cnt", frame_cnt, 16'h0001);
        checkOutput("nom_busy", {15'd0, busy}, 16'h0001);

        // Signed sample in the accel_x slot
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b1, 8'h38);
        for (int i = 0; i < NB - 2; i++) applyStimulus(1'b0, 1'b1, 8'h20 + 8'(i));
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("sgn_accel_x", accel_x, 16'hFF38);
        checkOutput("sgn_neg200", ($signed(accel_x) == -16'sd200) ? 16'h1 : 16'h0, 16'h1);
        checkOutput("sgn_accel_y", accel_y, 16'h2021);
        checkOutput("sgn_cnt", frame_cnt, 16'h0002);

        // byte_valid strobes in IDLE are ignored
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h99);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("idle_busy", {15'd0, busy}, 16'h0000);
        checkOutput("idle_accel_x", accel_x, 16'hFF38);

        // Timeout after 5 bytes
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h60 + 8'(i));
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            n++;
        end while (!frame_err && n < TO + 10);
        checkOutput("to_latency", 16'(n - 1), 16'(TO + 1));
        checkOutput("to_busy", {15'd0, busy}, 16'h0000);
        checkOutput("to_cnt", frame_cnt, 16'h0002);
        checkOutput("to_accel_x", accel_x, 16'hFF38);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Restart mid-frame, with a byte coinciding with the second frame_start
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h70 + 8'(i));
        applyStimulus(1'b1, 1'b1, 8'h55);
        applyStimulus(1'b0, 1'b1, 8'hA0);
        checkOutput("rs_err", {15'd0, frame_err}, 16'h0001);
        for (int i = 1; i < NB; i++) applyStimulus(1'b0, 1'b1, 8'hA0 + 8'(i));
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rs_valid", {15'd0, frame_valid}, 16'h0001);
        checkOutput("rs_accel_x", accel_x, 16'hA0A1);
        checkOutput("rs_gyro_z", gyro_z, 16'hACAD);
        checkOutput("rs_cnt", frame_cnt, 16'h0003);

        // frame_cnt wrap from 0xFFFF
        @(negedge clk);
        #1;
        force dut.frame_cnt_q = 16'hFFFF;
        forceCntReq = 1'b1;
        @(negedge clk);
        #1;
        release dut.frame_cnt_q;
        forceCntReq = 1'b0;
        sendFrame(8'h30);
        checkOutput("wrap_cnt", frame_cnt, 16'h0000);
        checkOutput("wrap_accel_x", accel_x, 16'h3031);

        // Reset after byte 9 clears everything at once
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 8'h80 + 8'(i));
        #2;
        reset = 1'b1;
        frame_start = 1'b0;
        byte_valid = 1'b0;
        #1;
        checkOutput("mr_accel_x", accel_x, 16'h0000);
        checkOutput("mr_gyro_z", gyro_z, 16'h0000);
        checkOutput("mr_busy", {15'd0, busy}, 16'h0000);
        checkOutput("mr_err", {15'd0, frame_err}, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
        sendFrame(8'h40);
        checkOutput("post_valid", {15'd0, frame_valid}, 16'h0001);
        checkOutput("post_accel_x", accel_x, 16'h4041);
        checkOutput("post_cnt", frame_cnt, 16'h0001);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/mpu_frame_asm.md
MPU_FRAME_ASM -- requirements
Module: mpu_frame_asm

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 14, meaning bytes per burst frame (register 0x3B..0x48).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, meaning the maximum number of idle clk cycles allowed between bytes inside a frame.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port frame_start  input  1  single-cycle pulse issued when the I2C burst read is launched.
REQ-006 SHALL have port byte_valid  input  1  single-cycle strobe: byte_data is valid.
REQ-007 SHALL have port byte_data  input  8  received byte from the I2C master.
REQ-008 SHALL have ports accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z, each output 16, signed two's-complement samples of the last complete frame.
REQ-009 SHALL have port frame_valid  output  1  single-cycle pulse: new sample set published.
REQ-010 SHALL have port frame_err  output  1  single-cycle pulse: frame aborted.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port frame_cnt  output  16  count of published frames.

Function
REQ-013 SHALL implement states IDLE, COLLECT, PUBLISH and ABORT.
REQ-014 IDLE: frame_start -> clear byte index and idle timer, go to COLLECT; byte_valid is ignored.
REQ-015 COLLECT: each byte_valid writes byte_data into a shadow buffer at the byte index, increments the index and clears the idle timer.
REQ-016 Byte mapping SHALL be: even index -> high byte, odd index -> low byte; word order AX, AY, AZ, T, GX, GY, GZ.
REQ-017 Acceptance of byte NUM_BYTES-1 -> PUBLISH on the next edge.
REQ-018 PUBLISH SHALL, in one cycle, copy all seven shadow words to the outputs, assert frame_valid, increment frame_cnt (modulo 2^16, 0xFFFF -> 0x0000), and return to IDLE.
REQ-019 Latency SHALL be exactly 1 clk from the edge accepting the last byte to frame_valid high; the outputs SHALL change only in that same cycle.
REQ-020 Each COLLECT cycle without byte_valid SHALL increment the idle timer; when the timer reaches TIMEOUT_CYC, the block SHALL go to ABORT.
REQ-021 frame_start in COLLECT SHALL discard the partial frame, pulse frame_err in the next cycle, and restart COLLECT with index 0.
REQ-022 frame_start and byte_valid in the same COLLECT cycle: frame_start wins and the byte is dropped.
REQ-023 ABORT SHALL pulse frame_err for 1 cycle, leave the sample outputs and frame_cnt unchanged, and return to IDLE.
REQ-024 frame_start and byte_valid SHALL be ignored in PUBLISH and ABORT.
REQ-025 busy SHALL be high in COLLECT and PUBLISH, and low in IDLE and ABORT.
REQ-026 Partial shadow data SHALL never reach the outputs.

Reset
REQ-027 reset high SHALL immediately force state IDLE; all sample outputs, frame_cnt, byte index, idle timer and shadow buffer to 0; frame_valid, frame_err and busy to 0.
REQ-028 reset asserted mid-frame SHALL discard the frame without a frame_err pulse; after release, the block SHALL wait for a fresh frame_start.

Verification
REQ-029 Nominal: frame_start, then 14 bytes 0x01..0x0E -> frame_valid 1 clk after the 14th byte; accel_x=0x0102, accel_z=0x0506, temp=0x0708, gyro_z=0x0D0E; frame_cnt=1.
REQ-030 Signed: bytes FF 38 in the accel_x slot -> accel_x=0xFF38 (-200); other outputs per the bytes sent.
REQ-031 Timeout: frame_start, 5 bytes, then silence -> frame_err at TIMEOUT_CYC+1 clk after the 5th byte; outputs and frame_cnt unchanged; busy low.
REQ-032 Restart: frame_start, 8 bytes, frame_start, 14 bytes 0xA0..0xAD -> one frame_err, then one frame_valid with accel_x=0xA0A1.
REQ-033 Wrap/ignore: preload 65535 frames (or force frame_cnt=0xFFFF) and complete one frame -> frame_cnt=0x0000; byte_valid strobes in IDLE -> no state change.
REQ-034 Reset: assert reset after byte 9 -> all outputs 0 immediately; no frame_err; a full frame after release publishes correctly.
